// File: rtl/vid_bus_pkg.sv
// Video bus definitions shared by the frame-buffer target, the video controller and bus masters.
package vid_bus_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE  = 3'b000,
        CMD_WDATA = 3'b001,
        CMD_RREQ  = 3'b010,
        CMD_RDATA = 3'b011,
        CMD_WREQ  = 3'b100,
        CMD_WRESP = 3'b101
    } bus_cmd_t;

    localparam logic [1:0] BUS_BID = 2'b11;

    // Burst length code to beat count: 00=1, 01=2, 10=4, 11=8.
    function automatic logic [3:0] len_beats(input logic [1:0] len);
        return 4'd1 << len;
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Single-port frame-buffer word store: synchronous read with one cycle of latency, no reset.
module fb_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/fb_mem_target.sv
// Frame-buffer memory target: accepts write bursts and serves read bursts on the video bus.
module fb_mem_target
    import vid_bus_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        selin,
    input  logic [2:0]  cmdin,
    input  logic [1:0]  lenin,
    input  logic [31:0] addrdatain,
    input  logic        ackin,
    output logic [1:0]  reqout,
    output logic [2:0]  cmdout,
    output logic [1:0]  lenout,
    output logic [31:0] addrdataout,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, WR_RESP, WR_DATA, RD_WAIT, RD_BID, RD_DATA} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] idx;
    logic [AW-1:0] ram_addr;
    logic [1:0]    len;
    logic [2:0]    beat;
    logic [2:0]    lat;
    logic [31:0]   rdata;
    logic          wr_beat;
    logic          last_beat;
    logic          rd_adv;

    assign wr_beat   = (state == WR_DATA) && selin && (cmdin == CMD_WDATA);
    assign last_beat = (beat == 3'(len_beats(len) - 4'd1));
    // Once the grant is seen the RAM runs one word ahead of the output register,
    // so every read beat finds its word already fetched.
    assign rd_adv    = ((state == RD_BID) && ackin) || (state == RD_DATA);
    assign ram_addr  = rd_adv ? idx + 1'b1 : idx;

    fb_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wr_beat),
        .addr  (ram_addr),
        .wdata (addrdatain),
        .rdata (rdata)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (selin && cmdin == CMD_WREQ)
                    state_nxt = WR_RESP;
                else if (selin && cmdin == CMD_RREQ)
                    state_nxt = RD_WAIT;
            end
            WR_RESP: state_nxt = WR_DATA;
            WR_DATA: if (wr_beat && last_beat) state_nxt = IDLE;
            RD_WAIT: if (lat == 3'd0) state_nxt = RD_BID;
            RD_BID:  if (ackin) state_nxt = RD_DATA;
            RD_DATA: if (last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            len         <= '0;
            beat        <= '0;
            lat         <= '0;
            reqout      <= '0;
            cmdout      <= CMD_IDLE;
            lenout      <= '0;
            addrdataout <= '0;
            busy        <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && state_nxt != IDLE) begin
                idx  <= addrdatain[AW+1:2];
                len  <= lenin;
                beat <= '0;
                lat  <= 3'(RD_LAT - 1);
            end else begin
                if (state == RD_WAIT && lat != 3'd0)
                    lat <= lat - 3'd1;
                if (wr_beat || state == RD_DATA)
                    beat <= beat + 3'd1;
                if (wr_beat || rd_adv)
                    idx <= idx + 1'b1;
            end

            // Outputs follow the state being entered, keeping them registered.
            reqout      <= (state_nxt == RD_BID) ? BUS_BID : 2'b00;
            cmdout      <= (state_nxt == WR_RESP) ? CMD_WRESP :
                           (state_nxt == RD_DATA) ? CMD_RDATA : CMD_IDLE;
            lenout      <= (state_nxt == RD_DATA) ? len : 2'b00;
            addrdataout <= (state_nxt == RD_DATA) ? rdata : 32'h0;
            busy        <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_fb_mem_target.sv
// Directed bench for fb_mem_target: write/read bursts, grant delay, wrap, dropped traffic, reset.
module tb_fb_mem_target;
    import vid_bus_pkg::*;

    localparam int DEPTH  = 256;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        selin = 1'b0;
    logic [2:0]  cmdin = 3'b000;
    logic [1:0]  lenin = 2'b00;
    logic [31:0] addrdatain = 32'h0;
    logic        ackin = 1'b0;
    logic [1:0]  reqout;
    logic [2:0]  cmdout;
    logic [1:0]  lenout;
    logic [31:0] addrdataout;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [31:0] wd [8];
    logic [31:0] ed [8];

    always #5 clk = ~clk;

    fb_mem_target #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .selin       (selin),
        .cmdin       (cmdin),
        .lenin       (lenin),
        .addrdatain  (addrdatain),
        .ackin       (ackin),
        .reqout      (reqout),
        .cmdout      (cmdout),
        .lenout      (lenout),
        .addrdataout (addrdataout),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        selin = 1'b0; cmdin = 3'b000; lenin = 2'b00; addrdatain = 32'h0;
    endtask

    task automatic req(input logic [2:0] c, input logic [31:0] a, input logic [1:0] l);
        selin = 1'b1; cmdin = c; lenin = l; addrdatain = a;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req"},  32'(reqout), 32'h0);
        chk({tag, "_cmd"},  32'(cmdout), 32'h0);
        chk({tag, "_len"},  32'(lenout), 32'h0);
        chk({tag, "_data"}, addrdataout, 32'h0);
        chk({tag, "_busy"}, 32'(busy),   32'h0);
    endtask

    // Write burst of wd[0..N-1]; gap idle cycles precede every data beat.
    task automatic wr_burst(input logic [31:0] a, input logic [1:0] l, input int gap);
        int n = 1 << l;
        req(CMD_WREQ, a, l); cyc(); drive_idle();
        chk("wr_resp", 32'(cmdout), 32'(CMD_WRESP));
        chk("wr_busy", 32'(busy), 32'h1);
        cyc();
        chk("wr_resp_one_cycle", 32'(cmdout), 32'h0);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                cyc();
                chk("wr_wait_busy", 32'(busy), 32'h1);
            end
            selin = 1'b1; cmdin = CMD_WDATA; addrdatain = wd[i];
            cyc(); drive_idle();
            chk("wr_busy_after_beat", 32'(busy), (i == n - 1) ? 32'h0 : 32'h1);
        end
    endtask

    // Read burst expecting ed[0..N-1]; inj keeps a write request on the bus during every beat.
    task automatic rd_burst(input logic [31:0] a, input logic [1:0] l, input int ack_delay, input bit inj);
        int n = 1 << l;
        req(CMD_RREQ, a, l); cyc(); drive_idle();
        chk("rd_busy", 32'(busy), 32'h1);
        for (int k = 0; k < RD_LAT; k++) begin
            chk("rd_no_bid_yet", 32'(reqout), 32'h0);
            cyc();
        end
        chk("rd_bid", 32'(reqout), 32'h3);
        for (int d = 0; d < ack_delay; d++) begin
            cyc();
            chk("rd_bid_hold", 32'(reqout), 32'h3);
            chk("rd_no_data_before_grant", 32'(cmdout), 32'h0);
        end
        ackin = 1'b1; cyc(); ackin = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) cyc();
            chk("rd_beat_cmd",  32'(cmdout), 32'(CMD_RDATA));
            chk("rd_beat_len",  32'(lenout), 32'(l));
            chk("rd_beat_data", addrdataout, ed[i]);
            chk("rd_bid_dropped", 32'(reqout), 32'h0);
            if (inj) req(CMD_WREQ, 32'h0, 2'b00);
        end
        cyc(); drive_idle();
        chk_quiet("rd_end");
        cyc();
        chk("rd_no_late_resp", 32'(cmdout), 32'h0);
        chk("rd_idle_busy", 32'(busy), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        reset_n = 1'b0;
        cyc(); cyc();
        chk_quiet("reset");
        reset_n = 1'b1;
        cyc();

        // Write then read, 4 beats at 0x40
        wd[0] = 32'h00FF0000; wd[1] = 32'h0000FF00; wd[2] = 32'h000000FF; wd[3] = 32'h00123456;
        wr_burst(32'h40, 2'b10, 0);
        ed = wd;
        rd_burst(32'h40, 2'b10, 0, 1'b0);

        // 8-beat burst at 0x100 with grant 3 cycles after the bid
        for (int i = 0; i < 8; i++) wd[i] = 32'h00A00000 + 32'(i);
        wr_burst(32'h100, 2'b11, 0);
        ed = wd;
        rd_burst(32'h100, 2'b11, 3, 1'b0);

        // Wrap at the top of memory: indices 254, 255, 0, 1
        wd[0] = 32'h00111111; wd[1] = 32'h00222222; wd[2] = 32'h00333333; wd[3] = 32'h00444444;
        wr_burst(32'h3F8, 2'b10, 0);
        ed = wd;
        rd_burst(32'h3F8, 2'b10, 0, 1'b0);
        ed[0] = 32'h00333333; ed[1] = 32'h00444444;
        rd_burst(32'h401, 2'b01, 0, 1'b0);   // bit 10 and addr[1:0] ignored -> index 0

        // Deselected read request
        req(CMD_RREQ, 32'h40, 2'b00); selin = 1'b0;
        cyc();
        chk("desel_busy", 32'(busy), 32'h0);
        cyc(); cyc();
        chk("desel_req", 32'(reqout), 32'h0);
        chk("desel_busy_late", 32'(busy), 32'h0);
        drive_idle();

        // Requests during a burst are dropped
        ed[0] = 32'h00FF0000; ed[1] = 32'h0000FF00; ed[2] = 32'h000000FF; ed[3] = 32'h00123456;
        rd_burst(32'h40, 2'b10, 0, 1'b1);

        // Reset on the 2nd beat of an 8-beat read, then read again
        for (int i = 0; i < 8; i++) ed[i] = 32'h00A00000 + 32'(i);
        req(CMD_RREQ, 32'h100, 2'b11); cyc(); drive_idle();
        for (int k = 0; k < RD_LAT; k++) cyc();
        chk("rst_bid", 32'(reqout), 32'h3);
        ackin = 1'b1; cyc(); ackin = 1'b0;
        chk("rst_beat0", addrdataout, ed[0]);
        cyc();
        chk("rst_beat1", addrdataout, ed[1]);
        reset_n = 1'b0;
        cyc();
        chk_quiet("rst_mid");
        reset_n = 1'b1;
        rd_burst(32'h100, 2'b11, 0, 1'b0);

        // Write with wait states between data beats
        wd[0] = 32'h00C0FFEE; wd[1] = 32'h00BEEF00; wd[2] = 32'h00000ABC; wd[3] = 32'h00FEDCBA;
        wr_burst(32'h200, 2'b10, 1);
        ed = wd;
        rd_burst(32'h200, 2'b10, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
